// File: rtl/serial_operand_feeder.sv
// Bit-serial feeder for the serial magnitude comparator: captures an operand pair, clears the
// comparator, streams the bits MSB-first and then pulses done. Optional macro: SIGNED_CMP_EN.
module serial_operand_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             cmp_clear,
  output logic             a_out,
  output logic             b_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SIGNED_CMP_EN
  localparam logic SIGN_FLIP = 1'b1;
`else
  localparam logic SIGN_FLIP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             flip;

  assign accept = (state == IDLE) && in_valid && in_ready;
  // The MSB leaves the shift registers on the CLEAR->SHIFT edge; flipping it there
  // maps two's complement onto offset binary for the unsigned comparator.
  assign flip   = SIGN_FLIP & (state == CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = CLEAR;
      CLEAR:   state_n = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_a <= '0;
      sh_b <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sh_a <= op_a;
          sh_b <= op_b;
          cnt  <= CNT_W'(WIDTH);
        end
        CLEAR: begin
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
        end
        SHIFT: begin
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
          cnt  <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      cmp_clear <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_valid <= 1'b0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      cmp_clear <= (state_n == CLEAR);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      bit_valid <= (state_n == SHIFT);
      a_out     <= (state_n == SHIFT) & (sh_a[WIDTH-1] ^ flip);
      b_out     <= (state_n == SHIFT) & (sh_b[WIDTH-1] ^ flip);
    end
  end
endmodule
